// File: rtl/lab1_sweep_ctrl.sv
// Sweeps all 16 {a,b,c,d} vectors through three implementations of one
// function, records the truth table and per-vector disagreement.
module lab1_sweep_ctrl #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          CHECK_GOLDEN = 1'b0,
    parameter logic [15:0] EXPECTED     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f_gate,
    input  logic        f_flow,
    input  logic        f_udp,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [15:0] mismatch_mask,
    output logic [4:0]  mismatch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] tt_q, tt_d;
    logic [15:0] mm_q, mm_d;
    logic [4:0]  mcnt_q, mcnt_d;
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        mis;
    logic        golden_ok;

    assign mis = (f_flow != f_gate) | (f_udp != f_gate);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tt_d     = tt_q;
        mm_d     = mm_q;
        mcnt_d   = mcnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = 4'd0;
                    settle_d = 4'd0;
                    tt_d     = 16'd0;
                    mm_d     = 16'd0;
                    mcnt_d   = 5'd0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = 4'd0;
                    settle_d = 4'd0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            SAMPLE: begin
                // An aborted sample is dropped; earlier results stay.
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = 4'd0;
                    settle_d = 4'd0;
                end else begin
                    tt_d[idx_q] = f_gate;
                    mm_d[idx_q] = mis;
                    mcnt_d      = mcnt_q + {4'd0, mis};
                    if (idx_q == 4'hF) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next state so they leave flops directly.
    always_comb begin
        vec_d = 4'd0;
        unique case (state_d)
            DRIVE, SAMPLE: vec_d = idx_d;
            DONE:          vec_d = 4'hF;
            default:       vec_d = 4'd0;
        endcase
        golden_ok = !CHECK_GOLDEN || (tt_d == EXPECTED);
        busy_d    = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d    = (state_d == DONE);
        pass_d    = done_d && (mcnt_d == 5'd0) && golden_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            tt_q     <= 16'd0;
            mm_q     <= 16'd0;
            mcnt_q   <= 5'd0;
            vec_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            mm_q     <= mm_d;
            mcnt_q   <= mcnt_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign a             = vec_q[3];
    assign b             = vec_q[2];
    assign c             = vec_q[1];
    assign d             = vec_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign truth_table   = tt_q;
    assign mismatch_mask = mm_q;
    assign mismatch_cnt  = mcnt_q;

endmodule
